// File: rtl/dsconv_bn_relu_unit.sv
// Per-filter batch-norm scale/offset, ReLU and requantization for the dsconv accumulator stream.
// Optional build macro DSCONV_BN_ROUND_EN: round half up before the requantizing shift (default: floor).
module dsconv_bn_relu_unit #(
    parameter int ACC_W = 20,
    parameter int OUT_W = 8,
    parameter int SHIFT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_start,
    input  logic [2:0]              cfg_layer,
    input  logic [3:0]              cfg_filter,
    output logic                    busy,
    output logic                    wmem_start,
    output logic [2:0]              wmem_layer_sel,
    output logic [3:0]              wmem_filter_sel,
    input  logic signed [17:0]      wmem_p,
    input  logic signed [35:0]      wmem_q,
    input  logic                    wmem_ready,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [ACC_W-1:0] in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic                    out_last
);

    localparam int S1_W = ACC_W + 19;
    localparam logic signed [S1_W:0] OUT_MAX = {{(S1_W + 1 - OUT_W){1'b0}}, {OUT_W{1'b1}}};
`ifdef DSCONV_BN_ROUND_EN
    localparam logic signed [S1_W:0] RND_HALF = {{S1_W{1'b0}}, 1'b1} << (SHIFT - 1);
`endif

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, RUN, DRAIN} state_t;

    state_t                  state, state_nxt;
    logic signed [17:0]      p_reg;
    logic signed [35:0]      q_reg;
    logic signed [S1_W-1:0]  acc_ext, p_ext, q_ext, s1_nxt;
    logic signed [S1_W-1:0]  s1_p1;
    logic                    vld_p1, last_p1;
    logic                    advance, accept;

    // One extra bit of headroom so the rounding add can never wrap.
    function automatic logic [OUT_W-1:0] relu_sat(input logic signed [S1_W-1:0] y);
        logic signed [S1_W:0] yr;
        logic signed [S1_W:0] r;
`ifdef DSCONV_BN_ROUND_EN
        yr = {y[S1_W-1], y} + RND_HALF;
`else
        yr = {y[S1_W-1], y};
`endif
        r = yr >>> SHIFT;
        if (r[S1_W])
            return '0;
        else if (r > OUT_MAX)
            return '1;
        else
            return r[OUT_W-1:0];
    endfunction

    assign advance = !out_valid || out_ready;
    assign accept  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b1;
        wmem_start = 1'b0;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (cfg_start)
                    state_nxt = FETCH;
            end
            FETCH: begin
                wmem_start = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                if (wmem_ready)
                    state_nxt = RUN;
            end
            RUN: begin
                in_ready = advance;
                if (in_valid && advance && in_last)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (out_valid && out_ready && out_last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wmem_layer_sel  <= '0;
            wmem_filter_sel <= '0;
            p_reg           <= '0;
            q_reg           <= '0;
        end else begin
            if (state == IDLE && cfg_start) begin
                wmem_layer_sel  <= cfg_layer;
                wmem_filter_sel <= cfg_filter;
            end
            if (state == WAIT && wmem_ready) begin
                p_reg <= wmem_p;
                q_reg <= wmem_q;
            end
        end
    end

    assign acc_ext = {{19{in_data[ACC_W-1]}}, in_data};
    assign p_ext   = {{(S1_W - 18){p_reg[17]}}, p_reg};
    assign q_ext   = {{(S1_W - 36){q_reg[35]}}, q_reg};
    assign s1_nxt  = acc_ext * p_ext + q_ext;

    // Stage 1: full-precision scale and offset
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            s1_p1   <= '0;
        end else if (advance) begin
            vld_p1  <= accept;
            last_p1 <= accept && in_last;
            if (accept)
                s1_p1 <= s1_nxt;
        end
    end

    // Stage 2: shift, ReLU and saturation into the output register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (advance) begin
            out_valid <= vld_p1;
            out_last  <= vld_p1 && last_p1;
            if (vld_p1)
                out_data <= relu_sat(s1_p1);
        end
    end

endmodule

// File: tb/tb_dsconv_bn_relu_unit.sv
// Randomized scoreboard bench for dsconv_bn_relu_unit with a BN weights memory model.
module tb_dsconv_bn_relu_unit;

    localparam int ACC_W = 20;
    localparam int OUT_W = 8;
    localparam int SHIFT = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    cfg_start;
    logic [2:0]              cfg_layer;
    logic [3:0]              cfg_filter;
    logic                    busy;
    logic                    wmem_start;
    logic [2:0]              wmem_layer_sel;
    logic [3:0]              wmem_filter_sel;
    logic signed [17:0]      wmem_p = '0;
    logic signed [35:0]      wmem_q = '0;
    logic                    wmem_ready = 1'b0;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [ACC_W-1:0] in_data;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUT_W-1:0]        out_data;
    logic                    out_last;

    dsconv_bn_relu_unit #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_layer(cfg_layer), .cfg_filter(cfg_filter),
        .busy(busy), .wmem_start(wmem_start),
        .wmem_layer_sel(wmem_layer_sel), .wmem_filter_sel(wmem_filter_sel),
        .wmem_p(wmem_p), .wmem_q(wmem_q), .wmem_ready(wmem_ready),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit last;
        int cyc;
        bit lat;
    } exp_t;

    exp_t   sbq[$];
    int     stim[$];
    int     tbl_p[8][16];
    longint tbl_q[8][16];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     nstart = 0;
    int     rmode = 1;
    int     tog = 0;
    int     rdy_cnt = 0;
    bit     chk_busy = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: y = acc*p + q, (optional half-up rounding), arithmetic shift, clamp to [0, 2^OUT_W-1]
    function automatic int ref_act(input int acc, input int p, input longint q);
        longint y;
        y = longint'(acc) * longint'(p) + q;
`ifdef DSCONV_BN_ROUND_EN
        y = y + (longint'(1) <<< (SHIFT - 1));
`endif
        y = y >>> SHIFT;
        if (y < 0) return 0;
        if (y > longint'((1 << OUT_W) - 1)) return (1 << OUT_W) - 1;
        return int'(y);
    endfunction

    function automatic int rand_acc();
        if ($urandom_range(0, 1) == 1)
            return int'($urandom_range(0, 60000)) - 30000;
        return int'($urandom_range(0, 1048575)) - 524288;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (wmem_start) nstart = nstart + 1;

    // BN weights memory: data one cycle after the request, ready sticky (first fetch answers late)
    always @(posedge clk) begin
        if (rdy_cnt > 0) begin
            rdy_cnt <= rdy_cnt - 1;
            if (rdy_cnt == 1) wmem_ready <= 1'b1;
        end
        if (wmem_start) begin
            wmem_p <= 18'(tbl_p[wmem_layer_sel][wmem_filter_sel]);
            wmem_q <= 36'(tbl_q[wmem_layer_sel][wmem_filter_sel]);
            if (!wmem_ready) rdy_cnt <= 3;
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: out_ready = 1'b0;
                1: out_ready = 1'b1;
                2: begin out_ready = (tog % 3 == 0); tog++; end
                default: out_ready = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_busy) begin
                chk("busy_after_last", longint'(busy), 0);
                chk_busy = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%0d required=no_output", out_data);
                end else begin
                    e = sbq.pop_front();
                    chk("out_data", longint'(out_data), longint'(e.data));
                    chk("out_last", longint'(out_last), longint'(e.last));
                    if (e.lat) chk("latency", longint'(cyc - e.cyc), 2);
                    if (out_last) begin
                        chk("busy_at_last", longint'(busy), 1);
                        chk_busy = 1'b1;
                    end
                end
            end
        end
    end

    task automatic run_pass(input int l, input int f, input bit bubbles);
        int s0;
        int i;
        int guard;
        s0 = nstart;
        @(posedge clk); #1;
        cfg_start = 1'b1; cfg_layer = 3'(l); cfg_filter = 4'(f);
        @(negedge clk);
        chk("idle_before_start", longint'(busy), 0);
        @(posedge clk); #1;
        cfg_start = 1'b0; cfg_layer = 3'($urandom); cfg_filter = 4'($urandom);
        @(negedge clk);
        chk("wmem_start_t1", longint'(wmem_start), 1);
        chk("layer_sel", longint'(wmem_layer_sel), longint'(l));
        chk("filter_sel", longint'(wmem_filter_sel), longint'(f));
        chk("in_ready_fetch", longint'(in_ready), 0);
        @(negedge clk);
        chk("wmem_start_t2", longint'(wmem_start), 0);
        chk("in_ready_wait", longint'(in_ready), 0);
        i = 0;
        guard = 0;
        while (i < stim.size() && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
            cfg_start  = ($urandom_range(0, 7) == 0);
            cfg_layer  = 3'($urandom);
            cfg_filter = 4'($urandom);
            if (bubbles && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_data  = ACC_W'(rand_acc());
                in_last  = 1'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = ACC_W'(stim[i]);
                in_last  = (i == stim.size() - 1);
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                sbq.push_back('{ref_act(stim[i], tbl_p[l][f], tbl_q[l][f]), in_last, cyc, (rmode == 1)});
                i++;
            end
        end
        chk("input_accept_timeout", longint'(i), longint'(stim.size()));
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; cfg_start = 1'b0;
        guard = 0;
        while ((sbq.size() != 0 || busy) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_timeout", longint'(guard < 500), 1);
        chk("wmem_start_pulses", longint'(nstart - s0), 1);
        chk("layer_sel_held", longint'(wmem_layer_sel), longint'(l));
        chk("filter_sel_held", longint'(wmem_filter_sel), longint'(f));
        stim.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int cnt;
        int guard;
        for (int l = 0; l < 8; l++)
            for (int f = 0; f < 16; f++) begin
                tbl_p[l][f] = int'($urandom_range(0, 600)) - 100;
                tbl_q[l][f] = longint'($urandom_range(0, 2000000)) - 64'sd1000000;
            end
        tbl_p[0][0] = 236;  tbl_q[0][0] = -239327;
        tbl_p[7][10] = 0;   tbl_q[7][10] = 471;
        tbl_p[1][4] = 150;  tbl_q[1][4] = -206252;

        rst = 1'b1; cfg_start = 1'b0; cfg_layer = '0; cfg_filter = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_wmem_start", longint'(wmem_start), 0);
        chk("rst_layer_sel", longint'(wmem_layer_sel), 0);
        chk("rst_filter_sel", longint'(wmem_filter_sel), 0);
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_out_last", longint'(out_last), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed values plus random, including ReLU and saturation corners
        rmode = 1;
        stim = '{2000, 0, 100000, -524288, 524287};
        repeat (8) stim.push_back(rand_acc());
        run_pass(0, 0, 1'b1);

        stim = '{-524288, 0, 524287, 1000};
        run_pass(7, 10, 1'b0);

        // 16-beat burst under 1,0,0 output backpressure
        rmode = 2; tog = 0;
        repeat (16) stim.push_back(rand_acc());
        run_pass(2, 7, 1'b0);

        // Back-to-back passes with the memory already ready
        rmode = 1;
        repeat (6) stim.push_back(rand_acc());
        run_pass(1, 3, 1'b0);
        stim = '{2000, 30000, -3000};
        repeat (3) stim.push_back(rand_acc());
        run_pass(1, 4, 1'b0);

        rmode = 3;
        repeat (5) begin
            n = int'($urandom_range(1, 12));
            repeat (n) stim.push_back(rand_acc());
            run_pass(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 1'b1);
        end

        // Reset with two beats in flight
        rmode = 0;
        @(posedge clk); #1;
        cfg_start = 1'b1; cfg_layer = 3'd0; cfg_filter = 4'd5;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        cnt = 0; guard = 0;
        while (cnt < 2 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
            in_valid = 1'b1; in_data = ACC_W'(rand_acc()); in_last = 1'b0;
            @(negedge clk);
            if (in_ready) cnt++;
        end
        chk("rst_test_accepts", longint'(cnt), 2);
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("in_flight_out_valid", longint'(out_valid), 1);
        @(negedge clk);
        chk("midrst_busy", longint'(busy), 0);
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_out_data", longint'(out_data), 0);
        chk("midrst_out_last", longint'(out_last), 0);
        chk("midrst_in_ready", longint'(in_ready), 0);
        chk("midrst_layer_sel", longint'(wmem_layer_sel), 0);
        @(posedge clk); #1;
        rst = 1'b0; rmode = 1;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("post_rst_out_valid_count", longint'(cnt), 0);
        chk("post_rst_busy", longint'(busy), 0);

        stim = '{2000, 100000, 0};
        run_pass(0, 0, 1'b0);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", longint'(sbq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsconv_bn_relu_unit.md
# dsconv_bn_relu_unit

Applies per-filter batch normalization, ReLU and requantization to the accumulator stream of a depthwise-separable conv block. It sits directly downstream of the dsconv block's BN weights memory. It requests the scale p and offset q for one (layer, filter), then streams accumulator values through a 2-stage pipeline with valid/ready handshakes. It produces unsigned activations for the next layer's line buffer.

## Interface
- ACC_W, 20, signed accumulator input width
- OUT_W, 8, unsigned activation output width
- SHIFT, 16, arithmetic right shift applied after y = acc*p + q (range 1..30)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cfg_start  in  1  begin a filter pass; sampled only in IDLE
- cfg_layer  in  3  layer select, 0..7
- cfg_filter  in  4  filter select, 0..15
- busy  out  1  high in every state except IDLE
- wmem_start  out  1  one-cycle fetch request to BN weights memory
- wmem_layer_sel  out  3  registered copy of cfg_layer
- wmem_filter_sel  out  4  registered copy of cfg_filter
- wmem_p  in  18  signed scale, valid 1 cycle after wmem_start
- wmem_q  in  36  signed offset, valid 1 cycle after wmem_start
- wmem_ready  in  1  memory output valid (sticky high after first fetch)
- in_valid / in_ready  in / out  1  accumulator stream handshake
- in_data  in  ACC_W  signed accumulator
- in_last  in  1  final beat of this filter's stream
- out_valid / out_ready  out / in  1  activation stream handshake
- out_data  out  OUT_W  unsigned activation
- out_last  out  1  marks activation derived from in_last beat

## Operation
- FSM: IDLE -> FETCH -> WAIT -> RUN -> DRAIN -> IDLE.
- IDLE: on cfg_start, latch cfg_layer/cfg_filter into wmem_*_sel; go to FETCH.
- FETCH: wmem_start=1 for exactly this cycle; go to WAIT.
- WAIT: if wmem_ready=1, latch wmem_p/wmem_q into p_reg/q_reg and go to RUN. Otherwise stay.
- RUN: beat accepted when in_valid && in_ready. Accepting in_last=1 goes to DRAIN.
- DRAIN: in_ready=0. Go to IDLE in the cycle after the out_last beat handshakes.
- in_ready = (state==RUN) && advance, with advance = !out_valid || out_ready. A single global stall is used, with no bubble squeezing.
- Stage 1 (on advance): s1 = in_data*p_reg + sign-extended q_reg. Width ACC_W+19, full precision, no overflow. s1_valid/s1_last follow the accepted beat.
- Stage 2 (on advance): r = s1 >>> SHIFT (arithmetic). If r<0, output 0. If r > 2^OUT_W-1, output 2^OUT_W-1. Otherwise output r[OUT_W-1:0].
- p_reg=0 is legal; output is then relu/sat of q_reg >>> SHIFT.
- cfg_start outside IDLE is ignored. p_reg/q_reg are held constant from RUN until the next fetch.

## Timing
- Reset: state=IDLE. busy, wmem_start, wmem_layer_sel, wmem_filter_sel, in_ready, out_valid, out_data and out_last are all 0. s1_valid=0, p_reg=0, q_reg=0.
- rst mid-pass: pipeline contents are discarded and the FSM returns to IDLE next cycle. No out_valid is asserted after rst.
- cfg_start at cycle t: wmem_start at t+1, WAIT at t+2, in_ready earliest at t+3.
- Input-to-output latency is 2 cycles with no stall. Throughput is 1 beat/cycle while out_ready=1.
- While out_valid=1 and out_ready=0: out_data, out_last and stage 1 hold, and in_ready=0.
- out_last is asserted only on the beat derived from in_last. busy falls the cycle after that beat handshakes.

## Configuration
- DSCONV_BN_ROUND_EN defined: adds 2^(SHIFT-1) to s1 before the shift (round half up).
- DSCONV_BN_ROUND_EN undefined: plain arithmetic shift (floor).
- All other behaviour is identical in both builds.

## Test plan
- layer0/filter0 (p=236, q=-239327), SHIFT=16, in_data=2000, out_ready=1 -> out_data=3 (4 with ROUND_EN), 2 cycles after accept.
- Same config, in_data=0 -> out_data=0 (ReLU). in_data=100000 -> out_data=255 (saturation).
- layer7/filter10 (p=0, q=471), in_data=-524288 -> out_data=0 in both builds.
- 16-beat burst with out_ready toggling 1,0,0,1,…: no beat lost or duplicated, output order preserved, out_last only on beat 16, busy drops 1 cycle after it.
- Back-to-back passes (filter 3 then filter 4) with wmem_ready already high: wmem_start pulses once per pass, and the second pass uses p=150/q=-206252 (layer1) per selection.
- rst asserted mid-burst with 2 beats in flight -> all outputs 0 next cycle, state IDLE, and no subsequent out_valid.
